mem_stage_hs: RTL

Parametrised memory-access pipeline stage with a multi-cycle, latency-configurable on-chip data memory. It sits between the EX/MEM boundary and write-back. It resolves branches (pc_src), performs word/half/byte loads with sign or zero extension and the matching stores, and checks alignment. It holds upstream with a ready/valid handshake while an access is in flight, and it contains the MEM/WB output register.

---
 rtl/mem_pkg.sv | 66 ++++++
 rtl/mem_stage_ram.sv | 28 ++
 rtl/mem_stage_hs.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the memory-access stage: load-mode encodings, FSM states,
// and the alignment / lane-steering helpers used by the stage FSM.
package mem_pkg;

  localparam logic [1:0] LM_WORD = 2'b00;
  localparam logic [1:0] LM_HALF = 2'b01;
  localparam logic [1:0] LM_BYTE = 2'b10;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } state_e;

  // Reserved mode 11 falls into the word branch.
  function automatic logic is_misaligned(input logic [1:0] mode, input logic [1:0] addr_lo);
    logic bad;
    case (mode)
      LM_HALF: bad = addr_lo[0];
      LM_BYTE: bad = 1'b0;
      default: bad = (addr_lo != 2'b00);
    endcase
    return bad;
  endfunction

  function automatic logic [31:0] load_extract(input logic [1:0] mode, input logic [1:0] addr_lo,
                                               input logic zero_ext, input logic [31:0] word);
    logic [15:0] half_v;
    logic [7:0]  byte_v;
    logic [31:0] res;
    half_v = addr_lo[1] ? word[31:16] : word[15:0];
    case (addr_lo)
      2'b00:   byte_v = word[7:0];
      2'b01:   byte_v = word[15:8];
      2'b10:   byte_v = word[23:16];
      default: byte_v = word[31:24];
    endcase
    case (mode)
      LM_HALF: res = {{16{~zero_ext & half_v[15]}}, half_v};
      LM_BYTE: res = {{24{~zero_ext & byte_v[7]}}, byte_v};
      default: res = word;
    endcase
    return res;
  endfunction

  function automatic logic [3:0] store_be(input logic [1:0] mode, input logic [1:0] addr_lo);
    logic [3:0] be;
    case (mode)
      LM_HALF: be = addr_lo[1] ? 4'b1100 : 4'b0011;
      LM_BYTE: be = 4'b0001 << addr_lo;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  // Replicate sub-word store data across all lanes; byte enables pick the live one.
  function automatic logic [31:0] store_lanes(input logic [1:0] mode, input logic [31:0] wdata);
    logic [31:0] res;
    case (mode)
      LM_HALF: res = {2{wdata[15:0]}};
      LM_BYTE: res = {4{wdata[7:0]}};
      default: res = wdata;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/mem_stage_ram.sv
// Byte-enabled single-port synchronous RAM, 2^ADDR_W x 32, registered read data.
// Contents are intentionally not reset.
module mem_stage_ram #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              we,
  input  logic [3:0]        be,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);

  logic [31:0] mem_r [2**ADDR_W];

  // Byte-lane write plus read-before-write output register.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) begin
          mem_r[addr][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
    end
    rdata <= mem_r[addr];
  end

endmodule

// File: rtl/mem_stage_hs.sv
// MEM pipeline stage: branch resolution, aligned loads/stores to a multi-cycle RAM,
// ready/valid hold-off while an access is in flight, and the MEM/WB register.
module mem_stage_hs
  import mem_pkg::*;
#(
  parameter int ADDR_W  = 10,
  parameter int MEM_LAT = 2,
  parameter int RD_W    = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            in_mem_read,
  input  logic            in_mem_write,
  input  logic            in_mem_to_reg,
  input  logic            in_reg_write,
  input  logic [1:0]      in_load_mode,
  input  logic            in_load_unsigned,
  input  logic            in_branch,
  input  logic            in_zero,
  input  logic [31:0]     in_address,
  input  logic [31:0]     in_write_data,
  input  logic [RD_W-1:0] in_write_back_destination,
  output logic            pc_src,
  output logic            out_valid,
  output logic [31:0]     read_data,
  output logic [31:0]     address_out,
  output logic            mem_to_reg_out,
  output logic            reg_write_out,
  output logic [RD_W-1:0] write_back_destination_out,
  output logic            misalign_err
);

  localparam logic [3:0] LAT_INIT = 4'(MEM_LAT - 1);

  state_e            state_r;
  logic [3:0]        cnt_r;
  logic              ready_r;
  logic [31:0]       st_addr_r;
  logic [31:0]       st_wdata_r;
  logic [1:0]        st_mode_r;
  logic              st_unsigned_r;
  logic              st_read_r;
  logic              st_write_r;
  logic              st_mem_to_reg_r;
  logic              st_reg_write_r;
  logic [RD_W-1:0]   st_dest_r;

  logic              accept_s;
  logic              is_mem_s;
  logic              misalign_s;
  logic              ram_we_s;
  logic [ADDR_W-1:0] ram_addr_s;
  logic [31:0]       ram_rdata_s;

  assign in_ready   = ready_r;
  assign accept_s   = in_valid & ready_r;
  assign pc_src     = accept_s & in_branch & in_zero;
  assign is_mem_s   = in_mem_read | in_mem_write;
  assign misalign_s = is_mem_s & is_misaligned(in_load_mode, in_address[1:0]);

  // RAM reads every cycle; the word read on the edge before the final ACCESS
  // edge is what the MEM/WB register captures, so latency matches MEM_LAT.
  always_comb begin
    ram_we_s   = 1'b0;
    ram_addr_s = in_address[ADDR_W+1:2];
    if (state_r == ST_ACCESS) begin
      ram_addr_s = st_addr_r[ADDR_W+1:2];
      ram_we_s   = st_write_r & (cnt_r == 4'd0);
    end else begin
      ram_addr_s = in_address[ADDR_W+1:2];
      ram_we_s   = 1'b0;
    end
  end

  mem_stage_ram #(.ADDR_W(ADDR_W)) u_ram (
    .clk   (clk),
    .we    (ram_we_s),
    .be    (store_be(st_mode_r, st_addr_r[1:0])),
    .addr  (ram_addr_s),
    .wdata (store_lanes(st_mode_r, st_wdata_r)),
    .rdata (ram_rdata_s)
  );

  // Stage FSM, stage register and MEM/WB register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r                    <= ST_IDLE;
      cnt_r                      <= 4'd0;
      ready_r                    <= 1'b1;
      st_addr_r                  <= 32'd0;
      st_wdata_r                 <= 32'd0;
      st_mode_r                  <= LM_WORD;
      st_unsigned_r              <= 1'b0;
      st_read_r                  <= 1'b0;
      st_write_r                 <= 1'b0;
      st_mem_to_reg_r            <= 1'b0;
      st_reg_write_r             <= 1'b0;
      st_dest_r                  <= '0;
      out_valid                  <= 1'b0;
      read_data                  <= 32'd0;
      address_out                <= 32'd0;
      mem_to_reg_out             <= 1'b0;
      reg_write_out              <= 1'b0;
      write_back_destination_out <= '0;
      misalign_err               <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (accept_s && is_mem_s && !misalign_s) begin
            st_addr_r       <= in_address;
            st_wdata_r      <= in_write_data;
            st_mode_r       <= in_load_mode;
            st_unsigned_r   <= in_load_unsigned;
            st_read_r       <= in_mem_read & ~in_mem_write;
            st_write_r      <= in_mem_write;
            st_mem_to_reg_r <= in_mem_to_reg;
            st_reg_write_r  <= in_reg_write;
            st_dest_r       <= in_write_back_destination;
            cnt_r           <= LAT_INIT;
            ready_r         <= 1'b0;
            state_r         <= ST_ACCESS;
          end else if (accept_s) begin
            // Non-memory or misaligned: single-cycle completion, nothing touches the RAM.
            out_valid                  <= 1'b1;
            read_data                  <= 32'd0;
            address_out                <= in_address;
            mem_to_reg_out             <= in_mem_to_reg;
            reg_write_out              <= in_reg_write & ~misalign_s;
            write_back_destination_out <= in_write_back_destination;
            misalign_err               <= misalign_s;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_ACCESS: begin
          if (cnt_r == 4'd0) begin
            out_valid                  <= 1'b1;
            read_data                  <= st_read_r ?
                                          load_extract(st_mode_r, st_addr_r[1:0], st_unsigned_r, ram_rdata_s) :
                                          32'd0;
            address_out                <= st_addr_r;
            mem_to_reg_out             <= st_mem_to_reg_r;
            reg_write_out              <= st_reg_write_r;
            write_back_destination_out <= st_dest_r;
            misalign_err               <= 1'b0;
            ready_r                    <= 1'b1;
            state_r                    <= ST_IDLE;
          end else begin
            cnt_r <= cnt_r - 4'd1;
          end
        end
        default: begin
          ready_r <= 1'b1;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
